smi_req_frame_router: RTL and testbench
=======================================

# smi_req_frame_router

Splits the single upstream SMI request stream into a write-request stream and a read-request stream, using the frame type byte in the first flit of each frame. Sits directly upstream of the SMI-to-AXI write adaptor and its read counterpart. The write adaptor therefore only ever sees write request frames. Frames with any other type byte are discarded whole and counted.

## Interface
Parameters:
- DataIndexSize, 4: log2 of flit width in bytes; minimum 4.
- DataWidth, (1<<DataIndexSize)*8: flit data width in bits; derived.
- WriteReqId, 8'h02: frame type byte for write requests.
- ReadReqId, 8'h01: frame type byte for read requests.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arstn  in  1  reset; asynchronous assertion, active low.
- smiInReady  in  1  upstream flit valid.
- smiInEofc  in  8  0 means more flits follow; nonzero marks the last flit of the frame.
- smiInData  in  DataWidth  flit data; byte 0 of the first flit is the type byte.
- smiInStop  out  1  backpressure to the upstream source.
- smiWrReady / smiWrEofc / smiWrData / smiWrStop  out/out/out/in  1/8/DataWidth/1  write-request output stream.
- smiRdReady / smiRdEofc / smiRdData / smiRdStop  out/out/out/in  1/8/DataWidth/1  read-request output stream.
- dropCount  out  8  count of discarded frames; saturates at 255.

## Operation
Handshake:
- A flit transfers on any edge where Ready=1 and Stop=0. This applies to the input and to both outputs.
- Ready, once asserted, holds with Eofc and Data stable until the flit transfers.

Route state machine (registered):
- FirstFlit is the reset state. The route is decoded combinationally from smiInData[7:0]:
  - WriteReqId selects Wr.
  - ReadReqId selects Rd.
  - Any other value selects Drop.
- On a transferred first flit:
  - The flit is pushed to the selected output buffer; nothing is pushed for Drop.
  - The route is latched into routeQ.
  - If Eofc=0, go to InFrame. If Eofc!=0, stay in FirstFlit (single-flit frame).
  - For Drop, dropCount increments by 1, saturating at 255. It increments once per dropped frame, on the first flit only.
- InFrame: every transferred flit goes to routeQ's buffer, or is discarded when routeQ is Drop. Eofc is never inspected for type. A transferred flit with Eofc!=0 returns the FSM to FirstFlit.

Output buffers:
- Each output has an independent 2-entry FIFO. Ready is driven from a register at the FIFO head.
- Eofc and Data pass through unmodified, including the first flit's type byte.

Input stop:
- smiInStop is computed only from registered state, with no combinational path from smiInData or smiInReady:
  - runQ=0 gives 1.
  - Otherwise, in FirstFlit: wrFull OR rdFull.
  - Otherwise, in InFrame: wrFull if routeQ=Wr, rdFull if routeQ=Rd, 0 if routeQ=Drop.
- runQ resets to 0 and sets to 1 on the first edge after arstn deasserts.

Outputs are fully independent. A stalled Rd port never blocks a Wr frame in progress, and vice versa. The exception is a new first flit, which waits until both buffers are non-full.

## Timing
- Reset values: smiInStop=1; smiWrReady=0, smiRdReady=0; dropCount=0; FSM in FirstFlit; both FIFOs empty; Eofc and Data outputs 0.
- Latency: a flit accepted at edge N shows Ready at the output after edge N. This is 1 cycle when the buffer was empty.
- Throughput: 1 flit/cycle per stream with Stop held low.
- With Stop held high, a buffer accepts 2 flits, then backpressures the input. Accepted flits are never lost or duplicated.
- Simultaneous push and pop on a full FIFO is not allowed, because stop is already asserted. On a 1-entry FIFO, push and pop together keep the occupancy at 1.
- Reset mid-frame: all state clears immediately. Partially routed frames are abandoned and buffered flits are lost. After reset release, the next flit is treated as a first flit.
- Eofc values above DataWidth/8 are passed through unchanged and treated as last.

## Test plan
- Single-flit write frame (type 8'h02, Eofc=4), both Stops low: appears on Wr one cycle later. Rd stays idle. dropCount=0.
- Three-flit read frame (Eofc 0, 0, 16), then a two-flit write frame back-to-back: Rd carries exactly 3 flits and Wr exactly 2, in order, with no idle input cycles.
- Write frame with smiWrStop held high: input stalls after 2 flits. Release Stop: all flits are delivered intact. Rd traffic is unaffected.
- Frame with type 8'h7F, 4 flits: no output activity. smiInStop stays 0 during the body. dropCount=1. Send 300 such frames: dropCount saturates at 255.
- Reset mid-frame (arstn low for 1 cycle during flit 2 of 4): all Ready outputs go to 0 immediately and smiInStop=1. After release, the next flit is routed by its own type byte.
- Randomized interleaved frames with random Stop patterns: a scoreboard checks that per-port flit order and content match the source with the type filter applied.

Source files
------------

// File: rtl/smi_req_frame_router.sv
`default_nettype none
// ============================================================================
// Module   : smi_req_frame_router
// Purpose  : Splits one SMI request stream into write and read request
//            streams by the frame type byte; other frames are dropped whole.
// Revision : 1.0  initial release
// ============================================================================

// Two-entry buffer whose head lives in dedicated registers so Ready/Eofc/Data
// are driven straight from flops.
module smi_req_frame_router_fifo #(
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          arstn,
    input  logic          pushValid,
    input  logic [7:0]    pushEofc,
    input  logic [DW-1:0] pushData,
    input  logic          popStop,
    output logic          full,
    output logic          outReady,
    output logic [7:0]    outEofc,
    output logic [DW-1:0] outData
);

    logic          headValid_q;
    logic [7:0]    headEofc_q;
    logic [DW-1:0] headData_q;
    logic          tailValid_q;
    logic [7:0]    tailEofc_q;
    logic [DW-1:0] tailData_q;
    logic          popXfer;

    assign popXfer  = headValid_q & ~popStop;
    assign full     = tailValid_q;
    assign outReady = headValid_q;
    assign outEofc  = headEofc_q;
    assign outData  = headData_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            headValid_q <= 1'b0;
            headEofc_q  <= 8'd0;
            headData_q  <= '0;
            tailValid_q <= 1'b0;
            tailEofc_q  <= 8'd0;
            tailData_q  <= '0;
        end else if (popXfer) begin
            if (tailValid_q) begin
                headEofc_q  <= tailEofc_q;
                headData_q  <= tailData_q;
                tailValid_q <= pushValid;
                if (pushValid) begin
                    tailEofc_q <= pushEofc;
                    tailData_q <= pushData;
                end
            end else if (pushValid) begin
                headEofc_q <= pushEofc;
                headData_q <= pushData;
            end else begin
                headValid_q <= 1'b0;
            end
        end else if (pushValid) begin
            if (!headValid_q) begin
                headValid_q <= 1'b1;
                headEofc_q  <= pushEofc;
                headData_q  <= pushData;
            end else begin
                tailValid_q <= 1'b1;
                tailEofc_q  <= pushEofc;
                tailData_q  <= pushData;
            end
        end
    end

endmodule

module smi_req_frame_router #(
    parameter int          DataIndexSize = 4,
    parameter int          DataWidth     = (1 << DataIndexSize) * 8,
    parameter logic [7:0]  WriteReqId    = 8'h02,
    parameter logic [7:0]  ReadReqId     = 8'h01
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 smiInReady,
    input  logic [7:0]           smiInEofc,
    input  logic [DataWidth-1:0] smiInData,
    output logic                 smiInStop,
    output logic                 smiWrReady,
    output logic [7:0]           smiWrEofc,
    output logic [DataWidth-1:0] smiWrData,
    input  logic                 smiWrStop,
    output logic                 smiRdReady,
    output logic [7:0]           smiRdEofc,
    output logic [DataWidth-1:0] smiRdData,
    input  logic                 smiRdStop,
    output logic [7:0]           dropCount
);

    typedef enum logic [1:0] {
        RT_WR   = 2'd0,
        RT_RD   = 2'd1,
        RT_DROP = 2'd2
    } route_e;

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_FRAME  = 1'b1
    } state_e;

    state_e     state_q;
    route_e     route_q;
    logic       run_q;
    logic [7:0] dropCount_q;

    route_e     decodeRoute;
    route_e     activeRoute;
    logic       inXfer;
    logic       wrPush;
    logic       rdPush;
    logic       wrFull;
    logic       rdFull;

    always_comb begin
        decodeRoute = RT_DROP;
        if (smiInData[7:0] == WriteReqId) begin
            decodeRoute = RT_WR;
        end else if (smiInData[7:0] == ReadReqId) begin
            decodeRoute = RT_RD;
        end
    end

    assign activeRoute = (state_q == ST_FIRST) ? decodeRoute : route_q;

    // Stop depends on flops only, so upstream never sees a loop through Ready/Data.
    always_comb begin
        smiInStop = 1'b1;
        if (run_q) begin
            if (state_q == ST_FIRST) begin
                smiInStop = wrFull | rdFull;
            end else begin
                case (route_q)
                    RT_WR:   smiInStop = wrFull;
                    RT_RD:   smiInStop = rdFull;
                    default: smiInStop = 1'b0;
                endcase
            end
        end
    end

    assign inXfer    = smiInReady & ~smiInStop;
    assign wrPush    = inXfer & (activeRoute == RT_WR);
    assign rdPush    = inXfer & (activeRoute == RT_RD);
    assign dropCount = dropCount_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= ST_FIRST;
            route_q     <= RT_DROP;
            run_q       <= 1'b0;
            dropCount_q <= 8'd0;
        end else begin
            run_q <= 1'b1;
            if (inXfer) begin
                case (state_q)
                    ST_FIRST: begin
                        route_q <= decodeRoute;
                        if (smiInEofc == 8'd0) begin
                            state_q <= ST_FRAME;
                        end
                        if ((decodeRoute == RT_DROP) && (dropCount_q != 8'hFF)) begin
                            dropCount_q <= dropCount_q + 8'd1;
                        end
                    end
                    default: begin
                        if (smiInEofc != 8'd0) begin
                            state_q <= ST_FIRST;
                        end
                    end
                endcase
            end
        end
    end

    smi_req_frame_router_fifo #(
        .DW (DataWidth)
    ) u_wr_fifo (
        .clk       (clk),
        .arstn     (arstn),
        .pushValid (wrPush),
        .pushEofc  (smiInEofc),
        .pushData  (smiInData),
        .popStop   (smiWrStop),
        .full      (wrFull),
        .outReady  (smiWrReady),
        .outEofc   (smiWrEofc),
        .outData   (smiWrData)
    );

    smi_req_frame_router_fifo #(
        .DW (DataWidth)
    ) u_rd_fifo (
        .clk       (clk),
        .arstn     (arstn),
        .pushValid (rdPush),
        .pushEofc  (smiInEofc),
        .pushData  (smiInData),
        .popStop   (smiRdStop),
        .full      (rdFull),
        .outReady  (smiRdReady),
        .outEofc   (smiRdEofc),
        .outData   (smiRdData)
    );

endmodule
`default_nettype wire

// File: tb/tb_smi_req_frame_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_smi_req_frame_router
// Purpose  : Scoreboard bench for smi_req_frame_router.
// Revision : 1.0  initial release
// ============================================================================
module tb_smi_req_frame_router;

    localparam int DW   = 128;
    localparam int MAXW = 300;

    logic          clk = 1'b0;
    logic          arstn;
    logic          smiInReady;
    logic [7:0]    smiInEofc;
    logic [DW-1:0] smiInData;
    logic          smiInStop;
    logic          smiWrReady;
    logic [7:0]    smiWrEofc;
    logic [DW-1:0] smiWrData;
    logic          smiWrStop;
    logic          smiRdReady;
    logic [7:0]    smiRdEofc;
    logic [DW-1:0] smiRdData;
    logic          smiRdStop;
    logic [7:0]    dropCount;

    smi_req_frame_router dut (
        .clk        (clk),
        .arstn      (arstn),
        .smiInReady (smiInReady),
        .smiInEofc  (smiInEofc),
        .smiInData  (smiInData),
        .smiInStop  (smiInStop),
        .smiWrReady (smiWrReady),
        .smiWrEofc  (smiWrEofc),
        .smiWrData  (smiWrData),
        .smiWrStop  (smiWrStop),
        .smiRdReady (smiRdReady),
        .smiRdEofc  (smiRdEofc),
        .smiRdData  (smiRdData),
        .smiRdStop  (smiRdStop),
        .dropCount  (dropCount)
    );

    always #5 clk = ~clk;

    logic [DW+7:0] wrExp[$];
    logic [DW+7:0] rdExp[$];
    int nChecks = 0;
    int nPass   = 0;
    int wrCnt   = 0;
    int rdCnt   = 0;
    int inAcc   = 0;
    int inWaits = 0;
    int expDrop = 0;
    bit randStop = 0;
    bit frameDone;

    task automatic check_val(input string tag, input logic [DW+7:0] obs, input logic [DW+7:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Output monitors: a flit transfers on the next edge when Ready & !Stop here.
    always @(negedge clk) begin
        if (arstn) begin
            if (smiWrReady && !smiWrStop) begin
                if (wrExp.size() == 0) check_val("wr_unexpected", 1, 0);
                else check_val("wr_flit", {smiWrEofc, smiWrData}, wrExp.pop_front());
                wrCnt++;
            end
            if (smiRdReady && !smiRdStop) begin
                if (rdExp.size() == 0) check_val("rd_unexpected", 1, 0);
                else check_val("rd_flit", {smiRdEofc, smiRdData}, rdExp.pop_front());
                rdCnt++;
            end
        end
    end

    always @(posedge clk) begin
        if (randStop) begin
            #1;
            smiWrStop = ($urandom_range(0, 2) == 0);
            smiRdStop = ($urandom_range(0, 2) == 0);
        end
    end

    // Called at 1ns after a rising edge; returns at 1ns after the accepting edge.
    task automatic send_flit(input int route, input logic [7:0] eofc, input logic [DW-1:0] data);
        int w = 0;
        smiInReady = 1'b1;
        smiInEofc  = eofc;
        smiInData  = data;
        forever begin
            @(negedge clk);
            if (!smiInStop) break;
            w++;
            if (w > MAXW) begin
                check_val("in_timeout", 0, 1);
                smiInReady = 1'b0;
                return;
            end
        end
        if (route == 0) wrExp.push_back({eofc, data});
        else if (route == 1) rdExp.push_back({eofc, data});
        inAcc++;
        inWaits += w;
        @(posedge clk);
        #1;
        smiInReady = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] typ, input int nflits, input logic [7:0] lastEofc);
        int route;
        logic [DW-1:0] d;
        route = (typ == 8'h02) ? 0 : (typ == 8'h01) ? 1 : 2;
        if (route == 2 && expDrop < 255) expDrop++;
        for (int i = 0; i < nflits; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) d[7:0] = typ;
            send_flit(route, (i == nflits - 1) ? lastEofc : 8'd0, d);
        end
    endtask

    task automatic drain();
        int c = 0;
        while ((wrExp.size() != 0 || rdExp.size() != 0) && c < MAXW) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        check_val("drain_empty", wrExp.size() + rdExp.size(), 0);
    endtask

    int wr0, rd0, acc0, w0;

    initial begin
        arstn = 1'b0; smiInReady = 1'b0; smiInEofc = 8'd0; smiInData = '0;
        smiWrStop = 1'b0; smiRdStop = 1'b0;
        #1;
        check_val("rst_in_stop", smiInStop, 1);
        check_val("rst_ready", {smiWrReady, smiRdReady}, 0);
        check_val("rst_drop", dropCount, 0);
        check_val("rst_wr_out", {smiWrEofc, smiWrData}, 0);
        check_val("rst_rd_out", {smiRdEofc, smiRdData}, 0);
        repeat (3) @(posedge clk);
        #2 arstn = 1'b1;
        check_val("run_pre_stop", smiInStop, 1);
        @(posedge clk); #1;
        check_val("run_stop", smiInStop, 0);

        // Single-flit write frame, one-cycle latency
        send_frame(8'h02, 1, 8'd4);
        check_val("wr_latency", smiWrReady, 1);
        check_val("rd_idle", smiRdReady, 0);
        check_val("drop_zero", dropCount, 0);
        drain();

        // Back-to-back read (3) then write (2)
        wr0 = wrCnt; rd0 = rdCnt; w0 = inWaits;
        send_frame(8'h01, 3, 8'd16);
        send_frame(8'h02, 2, 8'd16);
        check_val("b2b_no_idle", inWaits - w0, 0);
        drain();
        check_val("b2b_rd_cnt", rdCnt - rd0, 3);
        check_val("b2b_wr_cnt", wrCnt - wr0, 2);

        // Write stalled while a read drains independently
        smiRdStop = 1'b1;
        send_frame(8'h01, 1, 8'd5);
        smiWrStop = 1'b1;
        wr0 = wrCnt; rd0 = rdCnt; acc0 = inAcc;
        frameDone = 0;
        fork
            begin send_frame(8'h02, 4, 8'd9); frameDone = 1; end
        join_none
        repeat (6) @(posedge clk);
        #2;
        check_val("stall_acc", inAcc - acc0, 2);
        check_val("stall_in_stop", smiInStop, 1);
        smiRdStop = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_val("stall_rd_flows", rdCnt - rd0, 1);
        check_val("stall_wr_held", wrCnt - wr0, 0);
        smiWrStop = 1'b0;
        for (int i = 0; i < MAXW && !frameDone; i++) @(posedge clk);
        check_val("stall_done", frameDone, 1);
        drain();
        check_val("stall_wr_cnt", wrCnt - wr0, 4);

        // Dropped frames
        wr0 = wrCnt; rd0 = rdCnt; w0 = inWaits;
        send_frame(8'h7F, 4, 8'd2);
        check_val("drop_no_stall", inWaits - w0, 0);
        check_val("drop_one", dropCount, 1);
        for (int i = 0; i < 299; i++) send_frame(8'h7F, 4, 8'd2);
        check_val("drop_sat", dropCount, 255);
        drain();
        check_val("drop_no_out", (wrCnt - wr0) + (rdCnt - rd0), 0);

        // Reset in the middle of a write frame
        smiInReady = 1'b1; smiInEofc = 8'd0;
        smiInData = {$urandom, $urandom, $urandom, $urandom};
        smiInData[7:0] = 8'h02;
        @(posedge clk); #1;
        smiInData = {$urandom, $urandom, $urandom, $urandom};
        #1 arstn = 1'b0;
        #1;
        check_val("mrst_ready", {smiWrReady, smiRdReady}, 0);
        check_val("mrst_in_stop", smiInStop, 1);
        check_val("mrst_drop", dropCount, 0);
        smiInReady = 1'b0;
        wrExp.delete(); rdExp.delete();
        expDrop = 0;
        @(posedge clk); #2 arstn = 1'b1;
        @(posedge clk); #1;
        wr0 = wrCnt; rd0 = rdCnt;
        send_frame(8'h01, 1, 8'd1);
        drain();
        check_val("mrst_rd_route", rdCnt - rd0, 1);
        check_val("mrst_wr_none", wrCnt - wr0, 0);

        // Randomised interleaved frames under random backpressure
        randStop = 1;
        for (int f = 0; f < 60; f++) begin
            logic [7:0] t;
            logic [7:0] e;
            int sel;
            sel = $urandom_range(0, 3);
            t = (sel == 0) ? 8'h01 : (sel == 1) ? 8'h02 : (sel == 2) ? 8'h7F : 8'($urandom);
            e = 8'($urandom_range(1, 255));
            send_frame(t, $urandom_range(1, 4), e);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end
        randStop = 0;
        @(posedge clk); #2;
        smiWrStop = 1'b0; smiRdStop = 1'b0;
        drain();
        check_val("rand_drop", dropCount, expDrop);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
